// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID->EX pipeline register with NZCV status ownership and kill counter
// Bubbles on failed condition or hazard; bypasses in-flight NZCV back to the condition checker.
module id_ex_stage_reg #(
   parameter int WORD_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int KILL_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      freeze,
   input  logic                      hazard,
   input  logic                      cond_flag,
   input  logic                      wb_en_in,
   input  logic                      mem_r_in,
   input  logic                      mem_w_in,
   input  logic                      b_in,
   input  logic                      s_in,
   input  logic [3:0]                exe_cmd_in,
   input  logic [WORD_WIDTH-1:0]     pc_in,
   input  logic [WORD_WIDTH-1:0]     val_rn_in,
   input  logic [WORD_WIDTH-1:0]     val_rm_in,
   input  logic                      imm_in,
   input  logic [11:0]               shift_operand_in,
   input  logic [23:0]               signed_imm_24_in,
   input  logic [REG_ADDR_WIDTH-1:0] dest_in,
   input  logic [REG_ADDR_WIDTH-1:0] src1_in,
   input  logic [REG_ADDR_WIDTH-1:0] src2_in,
   input  logic [3:0]                alu_status_in,
   output logic                      wb_en_out,
   output logic                      mem_r_out,
   output logic                      mem_w_out,
   output logic                      b_out,
   output logic                      s_out,
   output logic [3:0]                exe_cmd_out,
   output logic [WORD_WIDTH-1:0]     pc_out,
   output logic [WORD_WIDTH-1:0]     val_rn_out,
   output logic [WORD_WIDTH-1:0]     val_rm_out,
   output logic                      imm_out,
   output logic [11:0]               shift_operand_out,
   output logic [23:0]               signed_imm_24_out,
   output logic [REG_ADDR_WIDTH-1:0] dest_out,
   output logic [REG_ADDR_WIDTH-1:0] src1_out,
   output logic [REG_ADDR_WIDTH-1:0] src2_out,
   output logic                      valid_out,
   output logic [3:0]                status_out,
   output logic [3:0]                status_fwd,
   output logic [KILL_CNT_WIDTH-1:0] kill_count
);

   logic kill;
   logic load;
   logic ex_sets_flags;
   logic kill_cnt_sat;

   assign kill          = hazard | ~cond_flag;
   assign load          = ~flush & ~freeze;
   assign ex_sets_flags = s_out & valid_out;
   assign kill_cnt_sat  = &kill_count;

   // Control bits and valid are gated by kill; data fields always follow ID.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en_out         <= 1'b0;
         mem_r_out         <= 1'b0;
         mem_w_out         <= 1'b0;
         b_out             <= 1'b0;
         s_out             <= 1'b0;
         valid_out         <= 1'b0;
         exe_cmd_out       <= '0;
         pc_out            <= '0;
         val_rn_out        <= '0;
         val_rm_out        <= '0;
         imm_out           <= 1'b0;
         shift_operand_out <= '0;
         signed_imm_24_out <= '0;
         dest_out          <= '0;
         src1_out          <= '0;
         src2_out          <= '0;
      end else if (flush) begin
         wb_en_out         <= 1'b0;
         mem_r_out         <= 1'b0;
         mem_w_out         <= 1'b0;
         b_out             <= 1'b0;
         s_out             <= 1'b0;
         valid_out         <= 1'b0;
         exe_cmd_out       <= '0;
         pc_out            <= '0;
         val_rn_out        <= '0;
         val_rm_out        <= '0;
         imm_out           <= 1'b0;
         shift_operand_out <= '0;
         signed_imm_24_out <= '0;
         dest_out          <= '0;
         src1_out          <= '0;
         src2_out          <= '0;
      end else if (!freeze) begin
         wb_en_out         <= wb_en_in & ~kill;
         mem_r_out         <= mem_r_in & ~kill;
         mem_w_out         <= mem_w_in & ~kill;
         b_out             <= b_in & ~kill;
         s_out             <= s_in & ~kill;
         valid_out         <= ~kill;
         exe_cmd_out       <= exe_cmd_in;
         pc_out            <= pc_in;
         val_rn_out        <= val_rn_in;
         val_rm_out        <= val_rm_in;
         imm_out           <= imm_in;
         shift_operand_out <= shift_operand_in;
         signed_imm_24_out <= signed_imm_24_in;
         dest_out          <= dest_in;
         src1_out          <= src1_in;
         src2_out          <= src2_in;
      end
   end

   // The flag write belongs to the instruction already in EX, so flush does not cancel it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_out <= 4'b0000;
      end else if (ex_sets_flags && !freeze) begin
         status_out <= alu_status_in;
      end
   end

   assign status_fwd = ex_sets_flags ? alu_status_in : status_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kill_count <= '0;
      end else if (load && kill && !kill_cnt_sat) begin
         kill_count <= kill_count + 1'b1;
      end
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID→EX pipeline register of the 5-stage ARM core.
- Consumes the condition-check result for the instruction in ID. Kills it (bubble) when its condition fails or a hazard is flagged.
- Owns the NZCV status register. Supplies a bypassed NZCV back to the condition checker.
- Keeps a saturating count of killed instructions for performance debug.

Parameters:
WORD_WIDTH, 32, width of PC and operand values
REG_ADDR_WIDTH, 4, register-file address width
KILL_CNT_WIDTH, 16, width of killed-instruction counter

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  branch taken in EX; bubble next cycle
freeze  input  1  stall; hold all stage registers
hazard  input  1  data hazard on ID instruction; insert bubble
cond_flag  input  1  condition-check result for ID instruction (1 = execute)
wb_en_in, mem_r_in, mem_w_in, b_in, s_in  input  1 each  ID control bits
exe_cmd_in  input  4  ALU command
pc_in  input  WORD_WIDTH  PC of ID instruction
val_rn_in, val_rm_in  input  WORD_WIDTH each  operand values
imm_in  input  1  immediate operand select
shift_operand_in  input  12  shifter operand field
signed_imm_24_in  input  24  branch offset
dest_in, src1_in, src2_in  input  REG_ADDR_WIDTH each  register addresses
alu_status_in  input  4  NZCV produced by EX ALU this cycle
*_out  output  same as each *_in above  registered copies
valid_out  output  1  EX holds a live instruction
status_out  output  4  architectural NZCV register
status_fwd  output  4  bypassed NZCV to condition checker
kill_count  output  KILL_CNT_WIDTH  saturating killed-instruction count

Behaviour:
- One clock; reset is asynchronous and active-high. rst=1 immediately forces to 0: every *_out, valid_out, status_out and kill_count.
- Stage-register update priority per rising edge: rst > flush > freeze > load.
- flush=1: all control outputs (wb_en, mem_r, mem_w, b, s) → 0, valid_out → 0, data outputs → 0. Flush wins over freeze and hazard.
- freeze=1, flush=0: every stage output holds its value.
- Load (flush=0, freeze=0): kill = hazard | ~cond_flag.
  - kill=0: all fields captured, valid_out → 1.
  - kill=1: control outputs and valid_out → 0. Data fields are still captured (don't-care downstream).
- Latency: exactly one cycle from ID inputs to *_out.
- Status register:
  - status_out ← alu_status_in at the edge when s_out=1, valid_out=1 and freeze=0.
  - flush does not block this update; it belongs to the older EX instruction.
  - Only N, Z, C and V are held; the register is 4 bits.
- status_fwd is combinational: alu_status_in when s_out & valid_out, else status_out. The ID condition check therefore sees flags of the immediately preceding S instruction with zero bubbles.
- kill_count:
  - Increments by 1 on each load-cycle edge with kill=1.
  - Does not count on flush or freeze cycles.
  - Saturates at all-ones; no wrap.
- Simultaneous hazard and cond_flag=0: one kill, counter +1.
- Reset mid-stall or mid-flush: reset dominates; first post-reset load edge behaves normally.
- Back-to-back S instructions: each updates status_out in its EX cycle; status_fwd always reflects the youngest.

Test Plan:
- Reset: drive all inputs 1, assert rst between edges → all outputs 0 without clock; deassert → first edge with cond_flag=1, hazard=0 loads pc_in=0x10, valid_out=1.
- Kill: cond_flag=0, wb_en_in=1, mem_w_in=1, dest_in=5 → next edge wb_en_out=0, mem_w_out=0, valid_out=0, dest_out=5, kill_count=1; repeat with hazard=1, cond_flag=0 → kill_count=2.
- Freeze/flush: load pc_in=0x20, then freeze=1 for 3 cycles with pc_in=0x24 → pc_out stays 0x20; assert flush with freeze → next edge valid_out=0, pc_out=0, kill_count unchanged.
- Status bypass: EX holds s_out=1, valid_out=1, alu_status_in=4'b0100 → status_fwd=0100 same cycle while status_out=0000; next edge status_out=0100. With s_out=0 → status_fwd=status_out.
- Status under freeze: s_out=1, freeze=1, alu_status_in=4'b1001 → status_out unchanged; release freeze → updates to 1001.
- Saturation: KILL_CNT_WIDTH=4, 20 consecutive kills → kill_count reaches 4'hF and stays.
